// File: rtl/tb_pkg.sv
// Shared types and helpers for the traceback ring buffer.
package tb_pkg;

    // Controller states: accepting commands, or rotating toward a seek target.
    typedef enum logic [0:0] {
        TB_IDLE = 1'b0,
        TB_SEEK = 1'b1
    } tb_state_e;

    // Traceback direction codes as produced by the PE array.
    localparam logic [1:0] TB_NONE = 2'd0;
    localparam logic [1:0] TB_DIAG = 2'd1;
    localparam logic [1:0] TB_UP   = 2'd2;
    localparam logic [1:0] TB_LEFT = 2'd3;

    typedef logic [31:0] tb_word_t;

    // Increment value by one, wrapping to zero at modulus.
    function automatic tb_word_t tb_mod_inc(input tb_word_t value, input tb_word_t modulus);
        tb_word_t next_v;
        next_v = value + 32'd1;
        if (next_v >= modulus) begin
            return 32'd0;
        end else begin
            return next_v;
        end
    endfunction

endpackage

// File: rtl/tb_ring_stage.sv
// One ring position: falling-edge register with async active-low clear and enable.
module tb_ring_stage #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on the falling edge when the ring shifts; hold otherwise.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/tb_ring_buffer.sv
// Circulating traceback buffer with fill tracking, overflow flag and seek-by-rotation.
module tb_ring_buffer
    import tb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int IDXW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rotate,
    input  logic             seek_req,
    input  logic [IDXW-1:0]  seek_idx,
    output logic [WIDTH-1:0] tail_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNTW-1:0]  count,
    output logic [IDXW-1:0]  rot_idx,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             seek_done,
    output logic             seek_err,
    output logic             overflow
);

    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [IDXW:0]   DEPTH_X  = (IDXW + 1)'(DEPTH);

    tb_state_e        state_r, state_s;
    logic [IDXW-1:0]  rot_idx_r, rot_idx_s;
    logic [IDXW-1:0]  target_r, target_s;
    logic [IDXW-1:0]  rot_inc_s;
    logic [CNTW-1:0]  count_r, count_s;
    logic             seek_done_r, seek_done_s;
    logic             seek_err_r, seek_err_s;
    logic             overflow_r, overflow_s;
    logic             shift_s;
    logic             load_s;
    logic             seek_oor_s;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] ring_q_s [DEPTH];

    assign rot_inc_s  = IDXW'(tb_mod_inc(tb_word_t'(rot_idx_r), tb_word_t'(DEPTH)));
    // Only reachable when DEPTH is not a power of two.
    assign seek_oor_s = ({1'b0, seek_idx} >= DEPTH_X);
    // New head value: fresh push data, or the tail wrapping around.
    assign src_s      = load_s ? push_data : ring_q_s[DEPTH-1];

    // Ring storage: position 0 takes the mux, every other position takes its predecessor.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            tb_ring_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .reset (reset),
                .en    (shift_s),
                .d     (src_s),
                .q     (ring_q_s[gi])
            );
        end else begin : g_body
            tb_ring_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .reset (reset),
                .en    (shift_s),
                .d     (ring_q_s[gi-1]),
                .q     (ring_q_s[gi])
            );
        end
    end

    // Command decode and next-state: seek beats push beats rotate; SEEK ignores all inputs.
    always_comb begin
        state_s     = state_r;
        rot_idx_s   = rot_idx_r;
        target_s    = target_r;
        count_s     = count_r;
        seek_done_s = 1'b0;
        seek_err_s  = 1'b0;
        overflow_s  = 1'b0;
        shift_s     = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            TB_IDLE: begin
                if (seek_req) begin
                    if (seek_oor_s) begin
                        seek_err_s  = 1'b1;
                        seek_done_s = 1'b1;
                    end else if (seek_idx == rot_idx_r) begin
                        seek_done_s = 1'b1;
                    end else begin
                        // The accepting edge already performs the first rotation.
                        shift_s   = 1'b1;
                        rot_idx_s = rot_inc_s;
                        target_s  = seek_idx;
                        if (rot_inc_s == seek_idx) begin
                            seek_done_s = 1'b1;
                        end else begin
                            state_s = TB_SEEK;
                        end
                    end
                end else if (push_valid) begin
                    shift_s   = 1'b1;
                    load_s    = 1'b1;
                    rot_idx_s = '0;
                    if (count_r == DEPTH_C) begin
                        overflow_s = 1'b1;
                    end else begin
                        count_s = count_r + CNT_ONE;
                    end
                end else if (rotate) begin
                    shift_s   = 1'b1;
                    rot_idx_s = rot_inc_s;
                end else begin
                    state_s = TB_IDLE;
                end
            end
            TB_SEEK: begin
                shift_s   = 1'b1;
                rot_idx_s = rot_inc_s;
                if (rot_inc_s == target_r) begin
                    state_s     = TB_IDLE;
                    seek_done_s = 1'b1;
                end else begin
                    state_s = TB_SEEK;
                end
            end
            default: begin
                state_s = TB_IDLE;
            end
        endcase
    end

    // Control registers, updated on the falling edge alongside the ring.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= TB_IDLE;
            rot_idx_r   <= '0;
            target_r    <= '0;
            count_r     <= '0;
            seek_done_r <= 1'b0;
            seek_err_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            rot_idx_r   <= rot_idx_s;
            target_r    <= target_s;
            count_r     <= count_s;
            seek_done_r <= seek_done_s;
            seek_err_r  <= seek_err_s;
            overflow_r  <= overflow_s;
        end
    end

    assign head_data = ring_q_s[0];
    assign tail_data = ring_q_s[DEPTH-1];
    assign count     = count_r;
    assign rot_idx   = rot_idx_r;
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CNTW{1'b0}});
    assign busy      = (state_r == TB_SEEK);
    assign seek_done = seek_done_r;
    assign seek_err  = seek_err_r;
    assign overflow  = overflow_r;

endmodule
